mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory/address port between two requesters (A = fetch, B = data stage).
//  Round-robin arbiter with fixed-latency transaction sequencing.
//  Outputs `sel` to drive the 2:1 WIDTH-bit word mux in front of the port.
//  Also outputs the registered port address and enable, plus per-requester done pulses.
// PARAMETERS
//  WIDTH    64  address width in bits
//  LATENCY  3   cycles mem_en stays high per transaction; legal range >= 1
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  reset     in   1      synchronous, active-high
//  reqA      in   1      requester A wants the port; held until doneA
//  addrA     in   WIDTH  requester A address; sampled only at grant
//  reqB      in   1      requester B wants the port; held until doneB
//  addrB     in   WIDTH  requester B address; sampled only at grant
//  sel       out  1      mux select, registered: 0 = A owns port, 1 = B owns port
//  mem_addr  out  WIDTH  registered address captured at grant
//  mem_en    out  1      port active; high for exactly LATENCY cycles per grant
//  doneA     out  1      one-cycle pulse in A's final mem_en cycle
//  doneB     out  1      one-cycle pulse in B's final mem_en cycle
//  busy      out  1      equals mem_en
// BEHAVIOUR
//  - Reset values: state=IDLE, sel=0, mem_addr=0, mem_en=0, doneA=0, doneB=0, busy=0.
//    Also on reset: last_grant=B, so A wins the first tie; counter=0.
//  - Reset mid-transaction: abort; outputs reach reset values at that edge; no done pulse.
//  - FSM states: IDLE, BUSY_A, BUSY_B.
//  - Arbitration runs in IDLE and in the final BUSY cycle (counter==0).
//    Only one requesting: grant it.
//    Both requesting: grant the one opposite last_grant.
//  - Grant is registered. At the grant edge:
//    state <= BUSY_x; sel <= x; mem_addr <= addr_x; mem_en <= 1;
//    counter <= LATENCY-1; last_grant <= x.
//  - Each BUSY cycle with counter>0: counter decrements.
//  - BUSY cycle with counter==0: done_x=1 (registered, aligned with last mem_en).
//    Next edge goes to BUSY_y if a new grant is made; otherwise to IDLE with mem_en=0.
//    No bubble between back-to-back grants.
//  - In the done cycle, the completing requester's req is ignored for arbitration.
//    That requester is re-grantable at the earliest one cycle later, via IDLE.
//    This makes A,B alternate when both hold req.
//  - addr_x changes after grant are ignored; mem_addr is stable for the whole transaction.
//  - Dropping req_x mid-transaction does not abort it: full LATENCY, done still pulses.
//  - LATENCY=1: mem_en and done_x are high in the same single cycle.
//  - Counter width is $clog2(LATENCY+1); no wrap: it reloads only at a grant.
//  - sel holds its last value in IDLE (no glitching of the mux).
//  - doneA and doneB are never high together; at most one grant per edge.
// TESTING (LATENCY=3, WIDTH=64)
//  1. Hold reset 2 cycles -> all outputs 0; release with no req -> state stays IDLE, mem_en=0.
//  2. reqA=1, addrA=0x100 from t0:
//     -> t1..t3 sel=0, mem_en=1, mem_addr=0x100; doneA only at t3; t4 mem_en=0.
//  3. reqA=reqB=1 from reset, both held:
//     -> A (t1-t3), B (t4-t6, sel=1, no idle cycle), A (t7-t9), B ...; doneA/doneB alternate.
//  4. A busy; reqB rises at t2 -> B granted at t4 directly after doneA; mem_addr=addrB at t4.
//  5. Change addrA 0x100->0x200 at t2 and drop reqA at t2
//     -> mem_addr stays 0x100, mem_en for 3 cycles, doneA at t3.
//  6. reset at t2 of A transaction -> t3 all outputs 0, no doneA.
//     Then reqA=reqB=1 -> A granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between requester A (fetch) and B (data stage).
// Every grant holds the port for exactly LATENCY cycles; back-to-back grants have no bubble.
module mem_port_arbiter #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqA,
  input  logic [WIDTH-1:0] addrA,
  input  logic             reqB,
  input  logic [WIDTH-1:0] addrB,
  output logic             sel,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_en,
  output logic             doneA,
  output logic             doneB,
  output logic             busy
);

  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             last_reg, last_next;   // 0 = A granted last, 1 = B granted last
  logic             sel_reg, sel_next;
  logic [WIDTH-1:0] addr_reg, addr_next;
  logic             en_reg, en_next;
  logic             done_a_reg, done_a_next;
  logic             done_b_reg, done_b_next;

  logic arb_slot, elig_a, elig_b, grant_a, grant_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= 1'b1;
      sel_reg    <= 1'b0;
      addr_reg   <= '0;
      en_reg     <= 1'b0;
      done_a_reg <= 1'b0;
      done_b_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      last_reg   <= last_next;
      sel_reg    <= sel_next;
      addr_reg   <= addr_next;
      en_reg     <= en_next;
      done_a_reg <= done_a_next;
      done_b_reg <= done_b_next;
    end
  end

  // The requester finishing this cycle sits out arbitration, which forces alternation.
  always_comb begin
    arb_slot   = (state_reg == IDLE) || (cnt_reg == '0);
    elig_a     = reqA && (state_reg != BUSY_A);
    elig_b     = reqB && (state_reg != BUSY_B);
    grant_a    = arb_slot && elig_a && (!elig_b || last_reg);
    grant_b    = arb_slot && elig_b && (!elig_a || !last_reg);
    state_next = state_reg;
    if (grant_a) begin
      state_next = BUSY_A;
    end else if (grant_b) begin
      state_next = BUSY_B;
    end else if (arb_slot) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    cnt_next  = cnt_reg;
    last_next = last_reg;
    sel_next  = sel_reg;
    addr_next = addr_reg;
    if (grant_a || grant_b) begin
      cnt_next  = CW'(LATENCY - 1);
      last_next = grant_b;
      sel_next  = grant_b;
      addr_next = grant_b ? addrB : addrA;
    end else if (state_reg != IDLE && cnt_reg != '0) begin
      cnt_next = cnt_reg - CW'(1);
    end
    en_next     = (state_next != IDLE);
    done_a_next = (state_next == BUSY_A) && (cnt_next == '0);
    done_b_next = (state_next == BUSY_B) && (cnt_next == '0);
  end

  assign sel      = sel_reg;
  assign mem_addr = addr_reg;
  assign mem_en   = en_reg;
  assign busy     = en_reg;
  assign doneA    = done_a_reg;
  assign doneB    = done_b_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts every cycle's
// port outputs into a queue; an independent monitor pops and compares on each falling edge.
module tb_mem_port_arbiter;

  localparam int WIDTH   = 64;
  localparam int LATENCY = 3;
  localparam int NCYC    = 3000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             reqA = 1'b0, reqB = 1'b0;
  logic [WIDTH-1:0] addrA = '0, addrB = '0;
  logic             sel, mem_en, doneA, doneB, busy;
  logic [WIDTH-1:0] mem_addr;

  mem_port_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .reqA(reqA), .addrA(addrA), .reqB(reqB), .addrB(addrB),
    .sel(sel), .mem_addr(mem_addr), .mem_en(mem_en),
    .doneA(doneA), .doneB(doneB), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             sel;
    logic [WIDTH-1:0] addr;
    logic             en;
    logic             da;
    logic             db;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: owner 0 = none, 1 = A, 2 = B; remaining = port cycles left including this one.
  int               owner = 0;
  int               remaining = 0;
  int               last = 2;
  logic             m_sel = 1'b0;
  logic [WIDTH-1:0] m_addr = '0;

  function automatic logic [WIDTH-1:0] rand_addr();
    return {$urandom, $urandom};
  endfunction

  task automatic model_edge();
    exp_t e;
    bit   ca, cb;
    int   winner;
    if (reset) begin
      owner = 0; remaining = 0; last = 2; m_sel = 1'b0; m_addr = '0;
    end else if (owner == 0 || remaining == 1) begin
      ca = reqA && owner != 1;
      cb = reqB && owner != 2;
      winner = 0;
      if (ca && cb) winner = (last == 1) ? 2 : 1;
      else if (ca)  winner = 1;
      else if (cb)  winner = 2;
      if (winner != 0) begin
        owner = winner; remaining = LATENCY; last = winner;
        m_sel = (winner == 2);
        m_addr = (winner == 2) ? addrB : addrA;
      end else begin
        owner = 0; remaining = 0;
      end
    end else begin
      remaining--;
    end
    e.sel  = m_sel;
    e.addr = m_addr;
    e.en   = (owner != 0);
    e.da   = (owner == 1 && remaining == 1);
    e.db   = (owner == 2 && remaining == 1);
    if (e.da || e.db)
      $display("txn %s addr=%h done", e.da ? "A" : "B", m_addr);
    exp_q.push_back(e);
  endtask

  // Monitor: purely compares DUT outputs against the queued predictions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (sel !== e.sel) begin
          miscompares++; $display("FAIL sel: got %b want %b at %0t", sel, e.sel, $time);
        end
        if (mem_addr !== e.addr) begin
          miscompares++; $display("FAIL mem_addr: got %h want %h at %0t", mem_addr, e.addr, $time);
        end
        if (mem_en !== e.en) begin
          miscompares++; $display("FAIL mem_en: got %b want %b at %0t", mem_en, e.en, $time);
        end
        if (busy !== e.en) begin
          miscompares++; $display("FAIL busy: got %b want %b at %0t", busy, e.en, $time);
        end
        if (doneA !== e.da) begin
          miscompares++; $display("FAIL doneA: got %b want %b at %0t", doneA, e.da, $time);
        end
        if (doneB !== e.db) begin
          miscompares++; $display("FAIL doneB: got %b want %b at %0t", doneB, e.db, $time);
        end
      end
    end
  end

  // Stimulus: directed prefix (reset, idle, lone A, both held, mid-transaction reset), then random.
  initial begin
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (n < 1) begin
        reset = 1'b1;
      end else if (n < 5) begin
        reset = 1'b0; reqA = 1'b0; reqB = 1'b0;
      end else if (n < 12) begin
        reqA = (owner == 1 && remaining == 1) ? 1'b0 : 1'b1;
        addrA = (owner == 1 && remaining <= 2) ? 64'h200 : 64'h100;
      end else if (n < 16) begin
        reqA = 1'b0;
      end else if (n < 36) begin
        reqA = 1'b1; reqB = 1'b1;
        addrA = 64'hA000 + 64'(n); addrB = 64'hB000 + 64'(n);
      end else if (n == 36) begin
        reqA = 1'b1; reqB = 1'b0; addrA = 64'h100;
      end else if (n == 38) begin
        reset = 1'b1;
      end else if (n < 44) begin
        reset = 1'b0; reqA = 1'b1; reqB = 1'b1;
      end else begin
        reset = ($urandom_range(255) == 0);
        if (owner == 1 && remaining == 1) reqA = 1'b0;
        else if (!reqA) begin
          if ($urandom_range(2) == 0) begin reqA = 1'b1; addrA = rand_addr(); end
        end else if (owner == 1 && $urandom_range(9) == 0) reqA = 1'b0;
        if (owner == 2 && remaining == 1) reqB = 1'b0;
        else if (!reqB) begin
          if ($urandom_range(2) == 0) begin reqB = 1'b1; addrB = rand_addr(); end
        end else if (owner == 2 && $urandom_range(9) == 0) reqB = 1'b0;
        if ($urandom_range(3) == 0) addrA = rand_addr();
        if ($urandom_range(3) == 0) addrB = rand_addr();
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
